// File: rtl/video_pattern_source.sv
// Purpose    : raster test-pattern generator (const / H ramp / V ramp / checker) with Frame/Line markers, X/Y and FrameDone.
// Latency    : first pixel is presented the cycle after Enable is sampled high in IDLE; all outputs are registered.
// Backpressure: Valid/Ready; while Valid=1 and Ready=0 every pixel-side output holds; Ready is ignored when Valid=0.
//
// Ports:
//   nReset    async active-low reset        Clk       clock, posedge
//   Enable    run request (level)           Mode      pattern select, latched at frame start
//   Ready     downstream accept             Valid     Pixel/X/Y/Frame/Line meaningful
//   Pixel     pixel value                   Frame     first pixel of frame (0,0)
//   Line      first pixel of each line      X, Y      coordinates of presented pixel
//   FrameDone one-cycle pulse after the last pixel of a frame is accepted
module video_pattern_source #(
    parameter int          PIX_W     = 8,
    parameter int          H_ACTIVE  = 64,
    parameter int          V_ACTIVE  = 48,
    parameter int          H_BLANK   = 4,
    parameter logic [7:0]  CONST_VAL = 8'hAA,
    parameter int          XW        = $clog2(H_ACTIVE),
    parameter int          YW        = $clog2(V_ACTIVE)
) (
    input  logic             nReset,
    input  logic             Clk,
    input  logic             Enable,
    input  logic [1:0]       Mode,
    input  logic             Ready,
    output logic             Valid,
    output logic [PIX_W-1:0] Pixel,
    output logic             Frame,
    output logic             Line,
    output logic [XW-1:0]    X,
    output logic [YW-1:0]    Y,
    output logic             FrameDone
);

    // Blank counter runs 0..H_BLANK-1; keep at least one bit so the
    // H_BLANK=0 build still elaborates.
    localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic             r_valid;
    logic             r_frame;
    logic             r_line;
    logic [PIX_W-1:0] r_pixel;
    logic [BW-1:0]    r_blk;
    logic             r_done;

    state_t           w_state_nxt;
    logic [1:0]       w_mode_nxt;
    logic [XW-1:0]    w_x_nxt;
    logic [YW-1:0]    w_y_nxt;
    logic             w_valid_nxt;
    logic             w_frame_nxt;
    logic             w_line_nxt;
    logic [PIX_W-1:0] w_pixel_nxt;
    logic [BW-1:0]    w_blk_nxt;
    logic             w_done_nxt;

    logic w_xfer;
    logic w_x_last;
    logic w_y_last;
    logic w_blk_last;
    logic w_eol;
    logic w_start;

    // Pattern function; bit 3 of a coordinate narrower than 4 bits reads as 0,
    // hence the zero-padding before the shift.
    function automatic logic [PIX_W-1:0] pix_f(input logic [1:0]    m,
                                              input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
        logic xb3;
        logic yb3;
        xb3 = |(({4'b0000, x} >> 3) & (XW+4)'(1));
        yb3 = |(({4'b0000, y} >> 3) & (YW+4)'(1));
        case (m)
            2'd0:    pix_f = PIX_W'(CONST_VAL);
            2'd1:    pix_f = PIX_W'(x);
            2'd2:    pix_f = PIX_W'(y);
            default: pix_f = (xb3 ^ yb3) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
        endcase
    endfunction

    // Valid is only ever high in ACTIVE, so a transfer implies ACTIVE.
    assign w_xfer     = r_valid & Ready;
    assign w_x_last   = (r_x == XW'(H_ACTIVE - 1));
    assign w_y_last   = (r_y == YW'(V_ACTIVE - 1));
    assign w_blk_last = (H_BLANK > 0) && (int'(r_blk) == H_BLANK - 1);

    // End of line: either the blank period finished, or the last pixel went
    // out with no blank period configured.
    assign w_eol   = ((r_state == S_ACTIVE) && w_xfer && w_x_last && (H_BLANK == 0)) ||
                     ((r_state == S_HBLANK) && w_blk_last);
    // Frame start: from IDLE, or back-to-back after the last line.
    assign w_start = ((r_state == S_IDLE) && Enable) || (w_eol && w_y_last && Enable);

    // State register plus all registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
            r_pixel <= '0;
            r_blk   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
            r_frame <= w_frame_nxt;
            r_line  <= w_line_nxt;
            r_pixel <= w_pixel_nxt;
            r_blk   <= w_blk_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (Enable) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_xfer && w_x_last && (H_BLANK > 0)) w_state_nxt = S_HBLANK;
            end
            S_HBLANK: begin
                w_state_nxt = S_HBLANK;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Mid-frame the next line always follows; Enable only matters after
        // the last line.
        if (w_eol) begin
            w_state_nxt = (!w_y_last || Enable) ? S_ACTIVE : S_IDLE;
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        w_frame_nxt = r_frame;
        w_line_nxt  = r_line;
        w_blk_nxt   = r_blk;
        w_done_nxt  = w_xfer && w_x_last && w_y_last;

        if (w_start) begin
            w_mode_nxt  = Mode;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_valid_nxt = 1'b1;
            w_frame_nxt = 1'b1;
            w_line_nxt  = 1'b1;
        end else if (w_eol) begin
            if (!w_y_last) begin
                w_x_nxt     = '0;
                w_y_nxt     = r_y + YW'(1);
                w_valid_nxt = 1'b1;
                w_line_nxt  = 1'b1;
                w_frame_nxt = 1'b0;
            end else begin
                w_valid_nxt = 1'b0;
                w_frame_nxt = 1'b0;
                w_line_nxt  = 1'b0;
            end
        end else if ((r_state == S_ACTIVE) && w_xfer) begin
            w_frame_nxt = 1'b0;
            w_line_nxt  = 1'b0;
            if (!w_x_last) begin
                w_x_nxt = r_x + XW'(1);
            end else begin
                w_valid_nxt = 1'b0;
            end
        end

        if ((r_state == S_ACTIVE) && w_xfer && w_x_last) begin
            w_blk_nxt = '0;
        end else if ((r_state == S_HBLANK) && !w_blk_last) begin
            w_blk_nxt = r_blk + BW'(1);
        end

        // Pixel is derived from the values being loaded this edge, so it
        // always matches the X/Y it is presented with and holds under stall.
        w_pixel_nxt = pix_f(w_mode_nxt, w_x_nxt, w_y_nxt);
    end

    assign Valid     = r_valid;
    assign Pixel     = r_pixel;
    assign Frame     = r_frame;
    assign Line      = r_line;
    assign X         = r_x;
    assign Y         = r_y;
    assign FrameDone = r_done;

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: default 64x48/blank-4 instance (A) and a
// 300x6/no-blank instance (B), each checked against an expected-pixel queue
// filled when a frame is requested and drained on every accepted pixel.
module tb_video_pattern_source;

    logic Clk    = 1'b0;
    logic nReset = 1'b0;
    always #5 Clk = ~Clk;

    // Instance A: defaults
    logic       a_en   = 1'b0;
    logic [1:0] a_mode = 2'd0;
    logic       a_rdy  = 1'b0;
    logic       a_vld;
    logic [7:0] a_pix;
    logic       a_frame, a_line, a_fd;
    logic [5:0] a_x;
    logic [5:0] a_y;

    // Instance B: wide lines, no blanking
    logic       b_en   = 1'b0;
    logic [1:0] b_mode = 2'd0;
    logic       b_rdy  = 1'b0;
    logic       b_vld;
    logic [7:0] b_pix;
    logic       b_frame, b_line, b_fd;
    logic [8:0] b_x;
    logic [2:0] b_y;

    video_pattern_source u_dut_a (
        .nReset(nReset), .Clk(Clk), .Enable(a_en), .Mode(a_mode), .Ready(a_rdy),
        .Valid(a_vld), .Pixel(a_pix), .Frame(a_frame), .Line(a_line),
        .X(a_x), .Y(a_y), .FrameDone(a_fd)
    );

    video_pattern_source #(.H_ACTIVE(300), .V_ACTIVE(6), .H_BLANK(0)) u_dut_b (
        .nReset(nReset), .Clk(Clk), .Enable(b_en), .Mode(b_mode), .Ready(b_rdy),
        .Valid(b_vld), .Pixel(b_pix), .Frame(b_frame), .Line(b_line),
        .X(b_x), .Y(b_y), .FrameDone(b_fd)
    );

    typedef struct packed {
        logic        frame;
        logic        line;
        logic [7:0]  pix;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit   mon_a = 0, mon_b = 0, rnd_rdy = 0;
    bit   a_stall = 0, a_last = 0, a_egap = 0;
    bit   b_last = 0, b_egap = 0;
    int   a_gap = 0, b_gap = 0;
    int   a_fd_cnt = 0, b_fd_cnt = 0;
    int   a_xfers = 0, b_xfers = 0;
    exp_t a_hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int m, input int x, input int y);
        case (m)
            0:       return 8'hAA;
            1:       return 8'(x);
            2:       return 8'(y);
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic push_frame(input bit is_a, input int m);
        int   w;
        int   h;
        exp_t e;
        w = is_a ? 64 : 300;
        h = is_a ? 48 : 6;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.frame = (x == 0) && (y == 0);
                e.line  = (x == 0);
                e.pix   = exp_pix(m, x, y);
                e.x     = 16'(x);
                e.y     = 16'(y);
                if (is_a) qa.push_back(e);
                else      qb.push_back(e);
            end
        end
    endtask

    task automatic mon_a_step();
        exp_t o;
        exp_t e;
        o.frame = a_frame; o.line = a_line; o.pix = a_pix;
        o.x = 16'(a_x);    o.y = 16'(a_y);
        if (a_stall) chk("A_stall_hold", {a_vld, o}, {1'b1, a_hold});
        chk("A_framedone", a_fd, a_last);
        if (a_fd) a_fd_cnt++;
        if (a_egap) begin
            if (a_vld) begin
                chk("A_hblank_len", a_gap, 4);
                a_egap = 0;
            end else begin
                a_gap++;
            end
        end
        a_last = 0;
        if (a_vld && a_rdy) begin
            if (qa.size() == 0) begin
                chk("A_unexpected_xfer", 64'(qa.size()), 1);
            end else begin
                e = qa.pop_front();
                chk("A_pixel", 64'(o), 64'(e));
            end
            a_xfers++;
            a_last = (a_x == 6'd63) && (a_y == 6'd47);
            if ((a_x == 6'd63) && (a_y != 6'd47)) begin
                a_egap = 1;
                a_gap  = 0;
            end
        end
        a_stall = a_vld && !a_rdy;
        a_hold  = o;
    endtask

    task automatic mon_b_step();
        exp_t o;
        exp_t e;
        o.frame = b_frame; o.line = b_line; o.pix = b_pix;
        o.x = 16'(b_x);    o.y = 16'(b_y);
        chk("B_framedone", b_fd, b_last);
        if (b_fd) b_fd_cnt++;
        if (b_egap) begin
            if (b_vld) begin
                chk("B_no_gap", b_gap, 0);
                b_egap = 0;
            end else begin
                b_gap++;
            end
        end
        b_last = 0;
        if (b_vld && b_rdy) begin
            if (qb.size() == 0) begin
                chk("B_unexpected_xfer", 64'(qb.size()), 1);
            end else begin
                e = qb.pop_front();
                chk("B_pixel", 64'(o), 64'(e));
            end
            b_xfers++;
            b_last = (b_x == 9'd299) && (b_y == 3'd5);
            if ((b_x == 9'd299) && (b_y != 3'd5)) begin
                b_egap = 1;
                b_gap  = 0;
            end
        end
    endtask

    // One cycle: observe at the falling edge, then move inputs just after the
    // rising edge.
    task automatic tick();
        @(negedge Clk);
        if (nReset && mon_a) mon_a_step();
        if (nReset && mon_b) mon_b_step();
        @(posedge Clk);
        #1;
        if (rnd_rdy) a_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_fd(input bit is_a, input int n);
        int k;
        k = 0;
        while (((is_a ? a_fd_cnt : b_fd_cnt) < n) && (k < 20000)) begin
            tick();
            k++;
        end
        chk(is_a ? "A_fd_count" : "B_fd_count", 64'(is_a ? a_fd_cnt : b_fd_cnt), 64'(n));
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_valid"}, a_vld, 0);
        chk({tag, "_pixel"}, a_pix, 0);
        chk({tag, "_frame"}, a_frame, 0);
        chk({tag, "_line"},  a_line, 0);
        chk({tag, "_x"},     a_x, 0);
        chk({tag, "_y"},     a_y, 0);
        chk({tag, "_fdone"}, a_fd, 0);
    endtask

    initial begin
        int cnt;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        chk_a_zero("rst");
        chk("rst_b_valid", b_vld, 0);
        nReset = 1'b1;
        tick();

        // B: ramp frame (mode 1) then vertical ramp frame (mode 2), no blanking
        mon_b = 1;
        push_frame(0, 1);
        push_frame(0, 2);
        b_en = 1; b_mode = 2'd1; b_rdy = 1;
        tick();
        b_mode = 2'd2;
        chk("B_first_valid", b_vld, 1);
        cnt = 0;
        while (!b_fd && (cnt < 5000)) begin
            tick();
            cnt++;
        end
        chk("B_frame_cycles", cnt, 1800);
        b_en = 0;
        wait_fd(0, 2);
        repeat (3) tick();
        chk("B_idle_valid", b_vld, 0);
        chk("B_queue_empty", 64'(qb.size()), 0);
        chk("B_xfers", b_xfers, 3600);

        // A: frame 1 mode 0 at full rate, frame 2 mode 3 with random Ready
        mon_a = 1;
        push_frame(1, 0);
        push_frame(1, 3);
        chk("A_idle_before_en", a_vld, 0);
        a_en = 1; a_mode = 2'd0; a_rdy = 1;
        tick();
        chk("A_first_valid", a_vld, 1);
        chk("A_first_pixel", a_pix, 8'hAA);
        chk("A_first_x", a_x, 0);
        chk("A_first_y", a_y, 0);
        chk("A_first_frame", a_frame, 1);
        chk("A_first_line", a_line, 1);
        a_mode = 2'd3;
        wait_fd(1, 1);
        rnd_rdy = 1;
        cnt = 0;
        while (!(a_vld && (a_y == 6'd10)) && (cnt < 20000)) begin
            tick();
            cnt++;
        end
        chk("A_reach_line10", a_y, 10);
        // Drop Enable and change Mode mid-frame: frame 2 must finish in mode 3
        a_en = 0; a_mode = 2'd2;
        wait_fd(1, 2);
        rnd_rdy = 0; a_rdy = 1;
        repeat (10) tick();
        chk("A_idle_after_drop", a_vld, 0);
        chk("A_queue_empty_f2", 64'(qa.size()), 0);
        chk("A_xfers_f2", a_xfers, 6144);

        // A: re-enable picks up mode 2
        push_frame(1, 2);
        a_en = 1;
        tick();
        a_en = 0;
        chk("A_f3_frame", a_frame, 1);
        wait_fd(1, 3);
        repeat (5) tick();
        chk("A_queue_empty_f3", 64'(qa.size()), 0);

        // A: asynchronous reset at pixel (20,10), then restart
        push_frame(1, 1);
        a_en = 1; a_mode = 2'd1;
        cnt = 0;
        while (!(a_vld && (a_x == 6'd20) && (a_y == 6'd10)) && (cnt < 5000)) begin
            tick();
            cnt++;
        end
        chk("A_reach_20_10", {a_x, a_y}, {6'd20, 6'd10});
        mon_a  = 0;
        nReset = 1'b0;
        #1;
        chk_a_zero("arst");
        qa.delete();
        a_stall = 0; a_last = 0; a_egap = 0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        push_frame(1, 1);
        mon_a = 1;
        tick();
        chk("A_restart_valid", a_vld, 1);
        chk("A_restart_x", a_x, 0);
        chk("A_restart_y", a_y, 0);
        chk("A_restart_frame", a_frame, 1);
        a_en = 0;
        wait_fd(1, 4);
        repeat (10) tick();
        chk("A_final_idle", a_vld, 0);
        chk("A_queue_empty_end", 64'(qa.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_pattern_source.md
Name: video_pattern_source

Overview:
- Parametrised successor to the fixed-value pixel input handler; feeds the Hough front end.
- Generates a complete raster stream: active pixels plus Frame and Line start markers, X/Y coordinates, and end-of-frame indication.
- Selectable test patterns, Valid/Ready backpressure, and programmable horizontal blanking.
- Lets the downstream pipeline be exercised without a camera.

Parameters:
- PIX_W, 8: pixel width in bits.
- H_ACTIVE, 64: active pixels per line (>=2).
- V_ACTIVE, 48: active lines per frame (>=2).
- H_BLANK, 4: idle cycles after each line (0 allowed = no gap).
- CONST_VAL, 8'hAA: mode-0 pixel value; low PIX_W bits used, zero-extended if PIX_W>8.
- XW, clog2(H_ACTIVE): X coordinate width (derived).
- YW, clog2(V_ACTIVE): Y coordinate width (derived).

Ports:
- nReset  in  1  Reset; asynchronous, active-low.
- Clk  in  1  Clock; all state updates on posedge.
- Enable  in  1  Run request; level-sensitive.
- Mode  in  2  Pattern select; sampled at frame start only.
- Ready  in  1  Downstream accept.
- Valid  out  1  Pixel/X/Y/Frame/Line are meaningful.
- Pixel  out  PIX_W  Pixel value.
- Frame  out  1  High with the first pixel (X=0, Y=0) of each frame.
- Line  out  1  High with the first pixel (X=0) of every line, including line 0.
- X  out  XW  Column of current pixel.
- Y  out  YW  Row of current pixel.
- FrameDone  out  1  One-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- All outputs are registered.
- Reset: Valid=0, Pixel=0, Frame=0, Line=0, X=0, Y=0, FrameDone=0, state=IDLE, latched mode=0. Reset asserted mid-frame aborts immediately to these values; no partial-frame completion.
- Transfer rule: a pixel transfers on a posedge where Valid=1 and Ready=1.
- Backpressure: while Valid=1 and Ready=0, Pixel/X/Y/Frame/Line/Valid hold exactly. Ready has no effect when Valid=0.
- States:
  - IDLE -> ACTIVE: on posedge with Enable=1. That edge latches Mode and loads X=0, Y=0, Valid=1, Frame=1, Line=1. First pixel is visible the cycle after Enable is sampled (latency 1).
  - ACTIVE, transfer with X<H_ACTIVE-1: X+1, same Y; Frame=0, Line=0.
  - ACTIVE, transfer with X=H_ACTIVE-1, H_BLANK>0: Valid=0 -> HBLANK with blank counter=0.
  - ACTIVE, transfer with X=H_ACTIVE-1, H_BLANK=0: go directly to next-line/next-frame handling (below) with no gap.
  - HBLANK: Valid=0 for exactly H_BLANK cycles. Then next-line/next-frame handling.
- Next-line/next-frame handling:
  - Y<V_ACTIVE-1: Y+1, X=0, Valid=1, Line=1, Frame=0. Enable is ignored mid-frame; a frame always completes.
  - Y=V_ACTIVE-1 and Enable=1: new frame. X=0, Y=0, Valid=1, Frame=1, Line=1, Mode re-latched.
  - Y=V_ACTIVE-1 and Enable=0: -> IDLE, Valid=0.
- FrameDone: asserted for the single cycle following the transfer of pixel (H_ACTIVE-1, V_ACTIVE-1). Independent of H_BLANK and Ready thereafter.
- Pixel function, from latched mode and next X/Y; computed in the same edge that loads X/Y, so Pixel always matches the X/Y it is presented with:
  - 0: CONST_VAL.
  - 1: horizontal ramp, X zero-extended/truncated to PIX_W.
  - 2: vertical ramp, Y zero-extended/truncated to PIX_W.
  - 3: checkerboard, all-ones if (X[3]^Y[3])=1 else 0. Missing bits, where XW or YW <4, read as 0.
- Mode changes mid-frame have no effect until the next frame start.
- No counter wraps beyond its range; X never exceeds H_ACTIVE-1 and Y never exceeds V_ACTIVE-1.

Test Plan:
- Reset then Enable=1, Mode=0, Ready=1, defaults -> first Valid cycle after Enable has Pixel=8'hAA, X=0, Y=0, Frame=1, Line=1. Exactly 64 Valid cycles then 4 Valid=0 cycles per line. Frame=1 once per 48 lines. FrameDone pulses once after pixel (63,47).
- Mode=1, H_ACTIVE=300, PIX_W=8 -> Pixel at X=255 is 8'hFF, at X=256 is 8'h00. Mode=2 Pixel equals Y on every pixel of line 5.
- Mode=3 -> pixel (7,0)=0, (8,0)=8'hFF, (8,8)=0, (0,8)=8'hFF.
- Random Ready toggling (50%) over one full frame -> outputs stable whenever Valid=1 and Ready=0. Exactly 3072 transfers, in raster order, no duplicates or skips.
- Enable dropped at line 10; Mode changed to 2 mid-frame -> frame completes all 48 lines, still in the frame-start mode. Then IDLE, Valid=0. Re-assert Enable -> new frame uses Mode 2.
- H_BLANK=0 -> line n+1 pixel 0 directly follows line n pixel 63 with Line=1. nReset pulsed at (20,10) -> all outputs 0 asynchronously. After release with Enable=1, restart at (0,0) with Frame=1.
